// File: rtl/stage_id_pipe.sv
// stage_id_pipe: registered instruction-decode stage (IF/ID -> ID/EX).
//
// Decodes register addresses, bypasses same-cycle write-back data onto the
// operands, extends the immediate per opcode, detects load-use hazards and
// holds the decoded instruction in an ID/EX register with valid/ready on both
// sides. A saturating counter records the number of hazard bubbles inserted.
//
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready             upstream handshake
//   in_inst, in_newpc             instruction word and its PC+4
//   rf_addr_rs/rt, rf_data_rs/rt  regfile read addresses and combinational data
//   wb_we, wb_addr, wb_data       write-back port, bypassed onto the operands
//   ex_is_load, ex_rd             instruction in EX, for load-use detection
//   flush                         drop the ID/EX contents and the current input
//   out_valid/out_ready           downstream handshake
//   out_inst .. out_imm           registered ID/EX contents
//   stall_count                   saturating count of hazard bubbles

module stage_id_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [DATA_W-1:0] in_newpc,
    output logic [REG_AW-1:0] rf_addr_rs,
    output logic [REG_AW-1:0] rf_addr_rt,
    input  logic [DATA_W-1:0] rf_data_rs,
    input  logic [DATA_W-1:0] rf_data_rt,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [DATA_W-1:0] out_newpc,
    output logic [DATA_W-1:0] out_rega,
    output logic [DATA_W-1:0] out_regb,
    output logic [DATA_W-1:0] out_imm,
    output logic [CNT_W-1:0]  stall_count
);

    logic [5:0]        opcode;
    logic [15:0]       imm_field;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              slot_free;
    logic              hazard;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm_ext;

    logic              valid_q;
    logic [31:0]       inst_q;
    logic [DATA_W-1:0] newpc_q;
    logic [DATA_W-1:0] rega_q;
    logic [DATA_W-1:0] regb_q;
    logic [DATA_W-1:0] imm_q;
    logic [CNT_W-1:0]  stall_q;

    assign opcode    = in_inst[31:26];
    assign imm_field = in_inst[15:0];
    // Address fields are 5 bits; zero-extend or truncate to the regfile width.
    assign rs        = REG_AW'(in_inst[25:21]);
    assign rt        = REG_AW'(in_inst[20:16]);

    assign rf_addr_rs = rs;
    assign rf_addr_rt = rt;

    assign slot_free = !valid_q || out_ready;
    // Both fields are compared regardless of opcode; conservative on purpose.
    assign hazard    = in_valid && ex_is_load && (ex_rd != '0) &&
                       ((ex_rd == rs) || (ex_rd == rt));
    assign in_ready  = flush || (slot_free && !hazard);

    // Write-back bypass; register 0 is hardwired and never bypassed.
    assign op_a = (wb_we && (wb_addr != '0) && (wb_addr == rs)) ? wb_data : rf_data_rs;
    assign op_b = (wb_we && (wb_addr != '0) && (wb_addr == rt)) ? wb_data : rf_data_rt;

    always_comb begin
        imm_ext = {{(DATA_W-16){imm_field[15]}}, imm_field};
        case (opcode)
            6'h0C, 6'h0D, 6'h0E: imm_ext = {{(DATA_W-16){1'b0}}, imm_field};
            6'h0F:               imm_ext = DATA_W'({imm_field, 16'h0000});
            default:             ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            newpc_q <= '0;
            rega_q  <= '0;
            regb_q  <= '0;
            imm_q   <= '0;
            stall_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (slot_free && hazard) begin
            valid_q <= 1'b0;
            if (stall_q != {CNT_W{1'b1}}) begin
                stall_q <= stall_q + 1'b1;
            end
        end else if (slot_free && in_valid) begin
            valid_q <= 1'b1;
            inst_q  <= in_inst;
            newpc_q <= in_newpc;
            rega_q  <= op_a;
            regb_q  <= op_b;
            imm_q   <= imm_ext;
        end else if (slot_free) begin
            valid_q <= 1'b0;
        end
        // Otherwise EX is backpressuring and everything holds.
    end

    assign out_valid   = valid_q;
    assign out_inst    = inst_q;
    assign out_newpc   = newpc_q;
    assign out_rega    = rega_q;
    assign out_regb    = regb_q;
    assign out_imm     = imm_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_stage_id_pipe.sv
// tb_stage_id_pipe: directed scenarios plus randomized traffic for stage_id_pipe,
// checked against a transaction-level reference model kept in the bench.

module tb_stage_id_pipe;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned SAT    = (1 << CNT_W) - 1;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic [DATA_W-1:0] in_newpc;
    logic [REG_AW-1:0] rf_addr_rs;
    logic [REG_AW-1:0] rf_addr_rt;
    logic [DATA_W-1:0] rf_data_rs;
    logic [DATA_W-1:0] rf_data_rt;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ex_is_load;
    logic [REG_AW-1:0] ex_rd;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [DATA_W-1:0] out_newpc;
    logic [DATA_W-1:0] out_rega;
    logic [DATA_W-1:0] out_regb;
    logic [DATA_W-1:0] out_imm;
    logic [CNT_W-1:0]  stall_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: the ID/EX slot as a plain record.
    logic        m_valid;
    logic [31:0] m_inst, m_newpc, m_rega, m_regb, m_imm;
    int unsigned m_stall;

    stage_id_pipe #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW),
        .CNT_W (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_newpc   (in_newpc),
        .rf_addr_rs (rf_addr_rs),
        .rf_addr_rt (rf_addr_rt),
        .rf_data_rs (rf_data_rs),
        .rf_data_rt (rf_data_rt),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_newpc  (out_newpc),
        .out_rega   (out_rega),
        .out_regb   (out_regb),
        .out_imm    (out_imm),
        .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int unsigned f_rs(input logic [31:0] inst);
        return (inst >> 21) & 32'h1F;
    endfunction

    function automatic int unsigned f_rt(input logic [31:0] inst);
        return (inst >> 16) & 32'h1F;
    endfunction

    function automatic logic [31:0] model_imm(input logic [31:0] inst);
        int unsigned op;
        int unsigned v;
        op = inst >> 26;
        v  = inst & 32'hFFFF;
        if (op >= 12 && op <= 14) return v;
        if (op == 15) return v * 65536;
        if (v >= 32768) return v + 32'hFFFF_0000;
        return v;
    endfunction

    function automatic bit model_hazard();
        int unsigned rd;
        rd = ex_rd;
        return in_valid && ex_is_load && rd != 0 &&
               (rd == f_rs(in_inst) || rd == f_rt(in_inst));
    endfunction

    function automatic bit model_ready();
        return flush || ((!m_valid || out_ready) && !model_hazard());
    endfunction

    function automatic logic [31:0] model_operand(input int unsigned idx,
                                                  input logic [31:0] rf);
        int unsigned wa;
        wa = wb_addr;
        if (wb_we && wa != 0 && wa == idx) return wb_data;
        return rf;
    endfunction

    // Advance the model using the inputs present at the edge, then clock the DUT.
    task automatic tick();
        logic        n_valid;
        logic [31:0] n_inst, n_newpc, n_rega, n_regb, n_imm;
        int unsigned n_stall;
        bit          free;
        n_valid = m_valid; n_inst = m_inst; n_newpc = m_newpc;
        n_rega = m_rega; n_regb = m_regb; n_imm = m_imm; n_stall = m_stall;
        free = !m_valid || out_ready;
        if (reset) begin
            n_valid = 0; n_inst = 0; n_newpc = 0; n_rega = 0; n_regb = 0;
            n_imm = 0; n_stall = 0;
        end else if (flush) begin
            n_valid = 0;
        end else if (free && model_hazard()) begin
            n_valid = 0;
            if (n_stall < SAT) n_stall = n_stall + 1;
        end else if (free && in_valid) begin
            n_valid = 1;
            n_inst  = in_inst;
            n_newpc = in_newpc;
            n_rega  = model_operand(f_rs(in_inst), rf_data_rs);
            n_regb  = model_operand(f_rt(in_inst), rf_data_rt);
            n_imm   = model_imm(in_inst);
        end else if (free) begin
            n_valid = 0;
        end
        @(posedge clock);
        m_valid = n_valid; m_inst = n_inst; m_newpc = n_newpc;
        m_rega = n_rega; m_regb = n_regb; m_imm = n_imm; m_stall = n_stall;
        #1;
    endtask

    task automatic drive_idle();
        reset = 0; in_valid = 0; in_inst = 0; in_newpc = 0;
        rf_data_rs = 0; rf_data_rt = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
        ex_is_load = 0; ex_rd = 0; flush = 0; out_ready = 1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tick();
        n_cmp++;
        if ({out_valid, out_inst, out_newpc, out_rega, out_regb, out_imm, stall_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b inst=%h pc=%h a=%h b=%h imm=%h stall=%0d want all 0",
                     out_valid, out_inst, out_newpc, out_rega, out_regb, out_imm, stall_count);
        end
        reset = 0;
    endtask

    task automatic test_basic();
        in_inst = 32'h2022_0005; in_newpc = 32'h0000_1004;
        rf_data_rs = 7; rf_data_rt = 32'h55; in_valid = 1; out_ready = 1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_in_ready: got %b want 1", in_ready);
        end
        n_cmp++;
        if (rf_addr_rs !== 5'd1 || rf_addr_rt !== 5'd2) begin
            n_fail++; $display("FAIL basic_rf_addr: got %0d/%0d want 1/2", rf_addr_rs, rf_addr_rt);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_rega !== 32'd7 || out_imm !== 32'h5 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_out: valid=%b a=%h imm=%h rdy=%b want 1/7/5/1",
                     out_valid, out_rega, out_imm, in_ready);
        end
    endtask

    task automatic test_imm();
        logic [5:0]  ops  [3] = '{6'h08, 6'h0D, 6'h0F};
        logic [31:0] want [3] = '{32'hFFFF_FFF0, 32'h0000_FFF0, 32'hFFF0_0000};
        for (int i = 0; i < 3; i++) begin
            in_inst = {ops[i], 5'd1, 5'd2, 16'hFFF0};
            in_valid = 1;
            tick();
            n_cmp++;
            if (out_imm !== want[i] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL imm_op%h: got %h valid=%b want %h", ops[i], out_imm, out_valid, want[i]);
            end
        end
    endtask

    task automatic test_load_use();
        in_inst = {6'h08, 5'd3, 5'd5, 16'h0001};
        in_valid = 1; ex_is_load = 1; ex_rd = 3;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL loaduse_in_ready: got %b want 0", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || stall_count !== 4'd1) begin
            n_fail++;
            $display("FAIL loaduse_bubble: valid=%b stall=%0d want 0/1", out_valid, stall_count);
        end
        ex_is_load = 0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL loaduse_release_ready: got %b want 1", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_inst !== 32'h2065_0001 || stall_count !== 4'd1) begin
            n_fail++;
            $display("FAIL loaduse_accept: valid=%b inst=%h stall=%0d want 1/20650001/1",
                     out_valid, out_inst, stall_count);
        end
    endtask

    task automatic test_bypass();
        in_inst = {6'h00, 5'd1, 5'd4, 16'h0000};
        rf_data_rt = 0; wb_we = 1; wb_addr = 4; wb_data = 32'hDEAD_BEEF; in_valid = 1;
        tick();
        n_cmp++;
        if (out_regb !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL bypass_rt4: got %h want deadbeef", out_regb);
        end
        in_inst = {6'h00, 5'd1, 5'd0, 16'h0000};
        wb_addr = 0; rf_data_rt = 32'h1234_5678;
        tick();
        n_cmp++;
        if (out_regb !== 32'h1234_5678) begin
            n_fail++; $display("FAIL bypass_r0: got %h want 12345678", out_regb);
        end
        wb_we = 0;
    endtask

    task automatic test_backpressure_flush();
        int unsigned s0;
        in_inst = 32'h2109_00AA; in_valid = 1; out_ready = 1;
        tick();
        in_inst = 32'h214A_00BB; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready);
            end
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || out_inst !== 32'h2109_00AA || out_imm !== 32'hAA) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: valid=%b inst=%h imm=%h want 1/210900aa/aa",
                         i, out_valid, out_inst, out_imm);
            end
        end
        flush = 1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid);
        end
        ex_is_load = 1; ex_rd = 10; out_ready = 1;
        s0 = m_stall;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || stall_count !== CNT_W'(s0)) begin
            n_fail++;
            $display("FAIL flush_vs_hazard: valid=%b stall=%0d want 0/%0d", out_valid, stall_count, s0);
        end
        flush = 0; ex_is_load = 0;
    endtask

    task automatic test_saturation();
        in_inst = {6'h08, 5'd3, 5'd0, 16'h0}; in_valid = 1;
        ex_is_load = 1; ex_rd = 3; out_ready = 1;
        for (int i = 0; i < 20; i++) tick();
        n_cmp++;
        if (stall_count !== CNT_W'(SAT) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_saturate: stall=%0d valid=%b want %0d/0", stall_count, out_valid, SAT);
        end
        ex_is_load = 0;
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: op = 6'h08;
                1: op = 6'h0C;
                2: op = 6'h0D;
                3: op = 6'h0E;
                4: op = 6'h0F;
                default: op = 6'($urandom);
            endcase
            reset      = ($urandom_range(0, 59) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_inst    = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            in_newpc   = $urandom;
            rf_data_rs = $urandom;
            rf_data_rt = $urandom;
            wb_we      = $urandom_range(0, 1);
            wb_addr    = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            ex_is_load = ($urandom_range(0, 3) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 15) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++;
            if (in_ready !== model_ready()) begin
                n_fail++;
                $display("FAIL rand_in_ready[%0d]: got %b want %b", i, in_ready, model_ready());
            end
            tick();
            n_cmp++;
            if (out_valid !== m_valid || out_inst !== m_inst || out_newpc !== m_newpc ||
                out_rega !== m_rega || out_regb !== m_regb || out_imm !== m_imm ||
                stall_count !== CNT_W'(m_stall)) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got v=%b i=%h pc=%h a=%h b=%h imm=%h s=%0d want v=%b i=%h pc=%h a=%h b=%h imm=%h s=%0d",
                         i, out_valid, out_inst, out_newpc, out_rega, out_regb, out_imm, stall_count,
                         m_valid, m_inst, m_newpc, m_rega, m_regb, m_imm, m_stall);
            end
        end
        drive_idle();
    endtask

    task automatic test_reset_midstream();
        in_inst = 32'h2022_0005; in_newpc = 32'h44; rf_data_rs = 9; in_valid = 1;
        ex_is_load = 1; ex_rd = 2;
        tick();  // bubble: bumps the stall count
        ex_is_load = 0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || stall_count == '0) begin
            n_fail++;
            $display("FAIL midreset_setup: valid=%b stall=%0d want 1/nonzero", out_valid, stall_count);
        end
        reset = 1;
        tick();
        n_cmp++;
        if ({out_valid, out_inst, out_newpc, out_rega, out_regb, out_imm, stall_count} !== '0) begin
            n_fail++;
            $display("FAIL midreset_state: valid=%b inst=%h pc=%h a=%h b=%h imm=%h stall=%0d want all 0",
                     out_valid, out_inst, out_newpc, out_rega, out_regb, out_imm, stall_count);
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_imm();
        test_load_use();
        test_bypass();
        test_backpressure_flush();
        test_saturation();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_id_pipe.md
Name: stage_id_pipe

Overview:
- Registered, parametrised instruction-decode stage for the five-stage pipeline CPU. Sits between the IF/ID latch and the EX stage.
- Drives register-file read addresses and forwards same-cycle write-back data.
- Extends immediates per opcode, detects load-use hazards, and holds results in an ID/EX output register.
- Uses valid/ready handshakes on both sides, plus flush and a saturating stall counter.

Parameters:
- DATA_W, 32: register/PC/immediate datapath width; legal values are 32 or larger.
- REG_AW, 5: register address width.
- CNT_W, 16: stall counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_inst  in  32  instruction word.
- in_newpc  in  DATA_W  PC+4 of the instruction.
- rf_addr_rs  out  REG_AW  regfile read address A = in_inst[25:21], zero-extended or truncated to REG_AW.
- rf_addr_rt  out  REG_AW  regfile read address B = in_inst[20:16], same treatment.
- rf_data_rs  in  DATA_W  regfile read data A (combinational).
- rf_data_rt  in  DATA_W  regfile read data B (combinational).
- wb_we  in  1  write-back write enable this cycle.
- wb_addr  in  REG_AW  write-back destination.
- wb_data  in  DATA_W  write-back data.
- ex_is_load  in  1  instruction currently in EX is a load.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- flush  in  1  discard the ID/EX contents and the current input.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX accepts the output this cycle.
- out_inst  out  32  registered instruction.
- out_newpc  out  DATA_W  registered PC+4.
- out_rega  out  DATA_W  registered operand A.
- out_regb  out  DATA_W  registered operand B.
- out_imm  out  DATA_W  registered extended immediate.
- stall_count  out  CNT_W  number of hazard-stall cycles since reset.

Behaviour:
- Reset (synchronous, highest priority):
  - out_valid = 0; out_inst, out_newpc, out_rega, out_regb, out_imm = 0; stall_count = 0.
  - in_ready is combinational and evaluates normally during reset.
- Output slot free: `slot_free = !out_valid || out_ready`.
- Hazard:
  - `hazard = in_valid && ex_is_load && ex_rd != 0 && (ex_rd == rs || ex_rd == rt)`.
  - rs/rt are the decoded address fields. Both are compared for every opcode; this is conservative by design.
- in_ready = flush || (slot_free && !hazard).
- Per-clock register update, in priority order:
  1. reset.
  2. flush: out_valid <= 0; the input is consumed and dropped (in_ready = 1).
  3. slot_free && hazard: a bubble is inserted. out_valid <= 0, data registers hold, and stall_count increments, saturating at 2^CNT_W-1.
  4. slot_free && in_valid: all out_* are loaded and out_valid <= 1.
  5. slot_free && !in_valid: out_valid <= 0.
  6. Otherwise (out_valid && !out_ready): all outputs hold, because EX is backpressuring.
- Hazard while backpressured (not slot_free): the stall counter does not increment.
- Latency: one cycle from input acceptance to out_valid. Throughput is one instruction per cycle when there is no hazard and no backpressure.
- Write-back bypass (applies to operand A and, independently, to operand B):
  - Operand A = wb_data if wb_we && wb_addr != 0 && wb_addr == rs; otherwise rf_data_rs.
  - Operand B uses the same rule with rt and rf_data_rt.
  - Register 0 is never bypassed.
- Immediate, opcode = in_inst[31:26], imm = in_inst[15:0]:
  - 0x0C, 0x0D, 0x0E (andi/ori/xori): zero-extend imm to DATA_W.
  - 0x0F (lui): {zeros, imm, 16'b0} in DATA_W.
  - All other opcodes: sign-extend imm[15] to DATA_W.
- out_inst and out_newpc are copied unchanged.
- While out_valid = 0, the data outputs are don't-care to consumers but must hold their last value (no X).

Test Plan:
- Reset then in_inst=0x2022_0005 (addi rt=2, rs=1), rf_data_rs=7, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_rega=7, out_imm=0x0000_0005, in_ready stays 1.
- Immediate modes: imm=0xFFF0 with opcode 0x08 -> out_imm=0xFFFF_FFF0; same imm with 0x0D -> 0x0000_FFF0; same imm with 0x0F -> 0xFFF0_0000.
- Load-use: ex_is_load=1, ex_rd=3, input rs=3 -> in_ready=0; out_valid=0 on the next cycle; stall_count goes 0→1. Clear ex_is_load -> the instruction is accepted the following cycle.
- Bypass: wb_we=1, wb_addr=4, wb_data=0xDEAD_BEEF, rt=4, rf_data_rt=0 -> out_regb=0xDEAD_BEEF. Repeat with wb_addr=0 and rt=0 -> out_regb = rf_data_rt.
- Backpressure and flush:
  - out_valid=1, out_ready=0 for 3 cycles -> outputs stable and in_ready=0.
  - Assert flush -> in_ready=1 and out_valid=0 on the next edge.
  - Simultaneous flush and hazard -> flush wins and stall_count is unchanged.
- Reset mid-stream with out_valid=1 -> all outputs and stall_count read 0 on the next edge.
